// File: rtl/vmem_arbiter.sv
// Fixed-priority sequencer for the single-port frame buffer: VGA read > clear engine > host write.
// Defining VMEM_ARB_STATS_EN adds a saturating host-write stall counter on stall_cnt.
module vmem_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DATA_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_valid,
  input  logic [9:0]        h_addr,
  input  logic [9:0]        v_addr,
  output logic [DATA_W-1:0] vga_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [18:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [18:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] V_LAST = 9'(V_ACTIVE - 1);

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  clr_state_t        state;
  logic [9:0]        ch;
  logic [8:0]        cv;
  logic [DATA_W-1:0] color;
  logic              gnt_vga;
  logic              gnt_clr;
  logic              gnt_wr;
  logic              vld_p1;
  logic              unused_v_msb;

  assign unused_v_msb = v_addr[9];

  assign wr_ready = !rst && !vga_valid && !clr_busy;
  assign gnt_vga  = !rst && vga_valid;
  assign gnt_clr  = !rst && !vga_valid && clr_busy;
  assign gnt_wr   = wr_ready && wr_valid;

  always_comb begin
    mem_en    = gnt_vga || gnt_clr || gnt_wr;
    mem_we    = gnt_clr || gnt_wr;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_vga) begin
      mem_addr = {h_addr, v_addr[8:0]};
    end else if (gnt_clr) begin
      mem_addr  = {ch, cv};
      mem_wdata = color;
    end else if (gnt_wr) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
  end

  // Clear engine: the scan position only advances on cycles its write wins the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      ch       <= '0;
      cv       <= '0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            ch       <= '0;
            cv       <= '0;
          end
        end
        CLEAR: begin
          if (gnt_clr) begin
            if (ch == H_LAST) begin
              ch <= '0;
              if (cv == V_LAST) begin
                state    <= IDLE;
                clr_busy <= 1'b0;
                clr_done <= 1'b1;
              end else begin
                cv <= cv + 9'd1;
              end
            end else begin
              ch <= ch + 10'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && clr_start) color <= clr_color;
  end

  // p1: RAM data returns one cycle after the read address; blank to 0 when no read was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      vga_data <= '0;
    end else begin
      vld_p1   <= gnt_vga;
      vga_data <= vld_p1 ? mem_rdata : '0;
    end
  end

`ifdef VMEM_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (wr_valid && !wr_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vmem_arbiter.sv
// Scoreboard bench for vmem_arbiter: a pixel-index reference model predicts every RAM access and status.
module tb_vmem_arbiter;
  localparam int H    = 8;
  localparam int V    = 4;
  localparam int DW   = 24;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic          vga_valid;
  logic [9:0]    h_addr;
  logic [9:0]    v_addr;
  logic [DW-1:0] vga_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [18:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic          mem_en;
  logic          mem_we;
  logic [18:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  vmem_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .vga_valid(vga_valid), .h_addr(h_addr), .v_addr(v_addr), .vga_data(vga_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  // Registered single-port RAM attached to the DUT.
  logic [DW-1:0] ram [0:(1<<19)-1] = '{default: '0};
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic          we;
    logic [18:0]   addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    logic          en;
    logic          ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] vdata;
    logic [15:0]   stall;
  } stat_t;

  txn_t  mem_q[$];
  stat_t stat_q[$];
  int    nvec = 0;
  int    nerr = 0;

  // Reference model: image contents, clear progress as a linear pixel index.
  logic [DW-1:0] shadow [0:(1<<19)-1] = '{default: '0};
  bit            m_busy = 0;
  bit            m_done = 0;
  bit            m_pend = 0;
  bit            m_last_rdy = 0;
  int            m_idx = 0;
  int            m_stall = 0;
  logic [DW-1:0] m_color = '0;
  logic [DW-1:0] m_vd = '0;
  logic [DW-1:0] m_pval = '0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic void model_step();
    stat_t       s;
    txn_t        t;
    bit          rdy, g_v, g_c, g_w;
    logic [18:0] caddr;
    rdy   = !rst && !vga_valid && !m_busy;
    g_v   = !rst && vga_valid;
    g_c   = !rst && !vga_valid && m_busy;
    g_w   = rdy && wr_valid;
    caddr = {10'(m_idx % H), 9'(m_idx / H)};
    m_last_rdy = rdy;
    s.en    = g_v || g_c || g_w;
    s.ready = rdy;
    s.busy  = m_busy;
    s.done  = m_done;
    s.vdata = m_vd;
`ifdef VMEM_ARB_STATS_EN
    s.stall = 16'(m_stall);
`else
    s.stall = '0;
`endif
    stat_q.push_back(s);
    if (g_v) begin
      t.we = 1'b0; t.addr = {h_addr, v_addr[8:0]}; t.wdata = '0;
      mem_q.push_back(t);
    end else if (g_c) begin
      t.we = 1'b1; t.addr = caddr; t.wdata = m_color;
      mem_q.push_back(t);
    end else if (g_w) begin
      t.we = 1'b1; t.addr = wr_addr; t.wdata = wr_data;
      mem_q.push_back(t);
    end
    if (rst) begin
      m_busy = 0; m_done = 0; m_pend = 0; m_vd = '0; m_stall = 0;
    end else begin
      m_vd   = m_pend ? m_pval : '0;
      m_pend = g_v;
      if (g_v) m_pval = shadow[{h_addr, v_addr[8:0]}];
      if (wr_valid && !rdy && m_stall < 65535) m_stall++;
      m_done = 0;
      if (m_busy) begin
        if (g_c) begin
          shadow[caddr] = m_color;
          m_idx++;
          if (m_idx == NPIX) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end else if (clr_start) begin
        m_busy  = 1;
        m_idx   = 0;
        m_color = clr_color;
      end
      if (g_w) shadow[wr_addr] = wr_data;
    end
  endfunction

  task automatic step(input bit r, input bit vv, input logic [9:0] h, input logic [9:0] v,
                      input bit wv, input logic [18:0] wa, input logic [DW-1:0] wd,
                      input bit cs, input logic [DW-1:0] cc);
    @(posedge clk);
    #1;
    rst = r; vga_valid = vv; h_addr = h; v_addr = v;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    clr_start = cs; clr_color = cc;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0, 0, '0);
  endtask

  // Monitor: compares the DUT against the oldest prediction each cycle.
  stat_t mon_s;
  txn_t  mon_t;
  always @(negedge clk) begin
    if (stat_q.size() > 0) begin
      mon_s = stat_q.pop_front();
      chk("mem_en", 32'(mem_en), 32'(mon_s.en));
      chk("wr_ready", 32'(wr_ready), 32'(mon_s.ready));
      chk("clr_busy", 32'(clr_busy), 32'(mon_s.busy));
      chk("clr_done", 32'(clr_done), 32'(mon_s.done));
      chk("vga_data", 32'(vga_data), 32'(mon_s.vdata));
      chk("stall_cnt", 32'(stall_cnt), 32'(mon_s.stall));
      if (mem_en === 1'b1) begin
        if (mem_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL mem_access: got unexpected access addr %h expected none at %0t", mem_addr, $time);
        end else begin
          mon_t = mem_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(mon_t.we));
          chk("mem_addr", 32'(mem_addr), 32'(mon_t.addr));
          if (mon_t.we) chk("mem_wdata", 32'(mem_wdata), 32'(mon_t.wdata));
        end
      end else if (mon_s.en && mem_q.size() > 0) begin
        void'(mem_q.pop_front());
      end
    end
  end

  int            cnt;
  bit            seen;
  bit            r_b, vv_b, wv_b, cs_b, hold;
  logic [18:0]   wa_b;
  logic [DW-1:0] wd_b;

  initial begin
    rst = 1'b1; vga_valid = 1'b0; h_addr = '0; v_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_start = 1'b0; clr_color = '0;
    for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 0, '0, '0, 0, '0);

    // Seed pixel (5,3), then read it back and let the pipeline blank out.
    step(0, 0, '0, '0, 1, 19'h00A03, 24'h123456, 0, '0);
    step(0, 1, 10'd5, 10'd3, 0, '0, '0, 0, '0);
    idle(3);

    step(0, 0, '0, '0, 1, 19'h00010, 24'hABCDEF, 0, '0);
    idle(1);

    // Host write held off by four VGA cycles.
    for (int i = 0; i < 4; i++) step(0, 1, 10'(i), 10'd1, 1, 19'h00020, 24'h55AA55, 0, '0);
    step(0, 0, '0, '0, 1, 19'h00020, 24'h55AA55, 0, '0);
    idle(1);

    // Full clear with a second start mid-clear that must be ignored.
    step(0, 0, '0, '0, 0, '0, '0, 1, 24'h00FF00);
    for (int i = 0; i < NPIX + 4; i++) step(0, 0, '0, '0, 0, '0, '0, (i == 10), 24'hFF0000);
    for (int i = 0; i < 6; i++) step(0, 1, 10'(i), 10'(i % V), 0, '0, '0, 0, '0);
    idle(2);

    // Clear interleaved with VGA reads every other cycle.
    step(0, 0, '0, '0, 0, '0, '0, 1, 24'h0000FF);
    cnt = 0;
    seen = 0;
    for (int i = 0; i < 4 * NPIX + 20 && !seen; i++) begin
      step(0, i[0], 10'(i % H), 10'(i % V), 0, '0, '0, 0, '0);
      if (clr_busy) cnt++;
      if (clr_done) seen = 1;
    end
    nvec++;
    if (!seen || cnt < 2 * NPIX - 1 || cnt > 2 * NPIX + 1) begin
      nerr++;
      $display("FAIL clear_duration: got %0d busy cycles (done=%0d) expected %0d +-1", cnt, seen, 2 * NPIX);
    end
    idle(2);

    // Reset in the middle of a clear.
    step(0, 0, '0, '0, 0, '0, '0, 1, 24'h777777);
    idle(NPIX / 2);
    step(1, 0, '0, '0, 0, '0, '0, 0, '0);
    idle(4);

    // Randomized traffic; the host holds its request until accepted.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      r_b  = ($urandom_range(0, 499) == 0);
      vv_b = ($urandom_range(0, 2) == 0);
      cs_b = ($urandom_range(0, 149) == 0);
      if (!(hold && !m_last_rdy)) begin
        wv_b = ($urandom_range(0, 1) == 1);
        wa_b = {10'($urandom_range(0, H + 3)), 9'($urandom_range(0, V + 1))};
        wd_b = 24'($urandom);
      end
      step(r_b, vv_b, 10'($urandom_range(0, H + 3)), 10'($urandom_range(0, V + 1)),
           wv_b, wa_b, wd_b, cs_b, 24'($urandom));
      hold = wv_b;
    end
    idle(NPIX + 4);

    @(negedge clk);
    #1;
    chk("stat_q_drained", 32'(stat_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
